// File: rtl/gate_op_sched.sv
// rtl/gate_op_sched.sv - round-robin scheduler sharing one bit-serial Nand-built gate cell
// Operands are captured at grant, evaluated LSB first through a single cell, result acked to owner.

module gate_nand (
  input  logic i_x,
  input  logic i_y,
  output logic o_z
);
  assign o_z = ~(i_x & i_y);
endmodule

module gate_cell (
  input  logic       i_a,
  input  logic       i_b,
  input  logic [2:0] i_op,
  output logic       o_y
);
  logic w_nab;
  logic w_na;
  logic w_nb;
  logic w_and;
  logic w_or;
  logic w_x1;
  logic w_x2;
  logic w_xor;

  gate_nand u_nab (.i_x(i_a),   .i_y(i_b),   .o_z(w_nab));
  gate_nand u_na  (.i_x(i_a),   .i_y(i_a),   .o_z(w_na));
  gate_nand u_nb  (.i_x(i_b),   .i_y(i_b),   .o_z(w_nb));
  gate_nand u_and (.i_x(w_nab), .i_y(w_nab), .o_z(w_and));
  gate_nand u_or  (.i_x(w_na),  .i_y(w_nb),  .o_z(w_or));
  // Classic four-Nand XOR reusing the a/b Nand term.
  gate_nand u_x1  (.i_x(i_a),   .i_y(w_nab), .o_z(w_x1));
  gate_nand u_x2  (.i_x(i_b),   .i_y(w_nab), .o_z(w_x2));
  gate_nand u_xor (.i_x(w_x1),  .i_y(w_x2),  .o_z(w_xor));

  always_comb begin
    o_y = 1'b0;
    case (i_op)
      3'd0:    o_y = w_nab;
      3'd1:    o_y = w_and;
      3'd2:    o_y = w_or;
      3'd3:    o_y = w_xor;
      3'd4:    o_y = w_na;
      default: o_y = 1'b0;
    endcase
  end
endmodule

module gate_op_sched #(
  parameter int N = 4,
  parameter int W = 16
) (
  input  logic           i_clock,
  input  logic           i_reset_n,
  input  logic [N-1:0]   i_req,
  input  logic [N*W-1:0] i_a,
  input  logic [N*W-1:0] i_b,
  input  logic [N*3-1:0] i_op,
  output logic [N-1:0]   o_ack,
  output logic [W-1:0]   o_y,
  output logic           o_busy
);
  localparam int ID_W  = $clog2(N);
  localparam int CNT_W = $clog2(W);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [N-1:0] ONE_HOT0 = N'(1);

  logic [1:0]       r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [2:0]       r_op;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  r_last;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     r_res;
  logic [W-1:0]     r_y;
  logic [N-1:0]     r_ack;

  logic             w_found;
  logic [ID_W-1:0]  w_grant;
  int               w_idx;
  logic [W-1:0]     w_sel_a;
  logic [W-1:0]     w_sel_b;
  logic [2:0]       w_sel_op;
  logic             w_cell;

  // Search upward from the last served requester so it gets lowest priority.
  always_comb begin
    w_found = 1'b0;
    w_grant = r_last;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(r_last) + k) % N;
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_grant = ID_W'(w_idx);
      end
    end
  end

  assign w_sel_a  = i_a[w_grant*W +: W];
  assign w_sel_b  = i_b[w_grant*W +: W];
  assign w_sel_op = i_op[w_grant*3 +: 3];

  gate_cell u_cell (
    .i_a  (r_a[0]),
    .i_b  (r_b[0]),
    .i_op (r_op),
    .o_y  (w_cell)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_id    <= '0;
      r_last  <= ID_W'(N - 1);
      r_cnt   <= '0;
      r_res   <= '0;
      r_y     <= '0;
      r_ack   <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_a     <= w_sel_a;
            r_b     <= w_sel_b;
            r_op    <= w_sel_op;
            r_id    <= w_grant;
            r_cnt   <= '0;
            r_res   <= '0;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // New bit enters at the MSB; after W shifts bit 0 has reached position 0.
          r_res <= {w_cell, r_res[W-1:1]};
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(W - 1)) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_y     <= r_res;
          r_ack   <= ONE_HOT0 << r_id;
          r_last  <= r_id;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_ack  = r_ack;
  assign o_y    = r_y;
  assign o_busy = (r_state != S_IDLE);
endmodule

// File: tb/tb_gate_op_sched.sv
// tb/tb_gate_op_sched.sv - directed and randomized checks of gate_op_sched against a word-level model

module tb_gate_op_sched;
  localparam int N = 4;
  localparam int W = 16;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] a_bus;
  logic [N*W-1:0] b_bus;
  logic [N*3-1:0] op_bus;
  logic [N-1:0]   ack;
  logic [W-1:0]   y;
  logic           busy;

  logic [W-1:0] ta [N];
  logic [W-1:0] tb [N];
  logic [2:0]   top [N];

  int checks = 0;
  int failures = 0;
  int model_last = N - 1;

  gate_op_sched #(.N(N), .W(W)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .i_req     (req),
    .i_a       (a_bus),
    .i_b       (b_bus),
    .i_op      (op_bus),
    .o_ack     (ack),
    .o_y       (y),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    case (op)
      3'd0:    return ~(a & b);
      3'd1:    return a & b;
      3'd2:    return a | b;
      3'd3:    return a ^ b;
      3'd4:    return ~a;
      default: return '0;
    endcase
  endfunction

  function automatic int next_grant(input logic [N-1:0] mask, input int last);
    for (int k = 1; k <= N; k++) begin
      if (mask[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      a_bus[i*W +: W] = ta[i];
      b_bus[i*W +: W] = tb[i];
      op_bus[i*3 +: 3] = top[i];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic randomize_req(input int i);
    ta[i]  = W'($urandom);
    tb[i]  = W'($urandom);
    top[i] = 3'($urandom_range(0, 7));
  endtask

  // Steps until an ack appears; latency is counted in edges from the call.
  task automatic wait_ack(input string tag, input int exp_id, input logic [W-1:0] exp_y,
                          input int exp_lat, output int busy_cyc);
    int cyc;
    logic [N-1:0] exp_ack;
    cyc = 0;
    busy_cyc = 0;
    for (int i = 1; i <= 60; i++) begin
      step();
      if (busy) busy_cyc++;
      if (ack != '0) begin
        cyc = i;
        break;
      end
    end
    exp_ack = '0;
    exp_ack[exp_id] = 1'b1;
    chk({tag, "_ack"}, 32'(ack), 32'(exp_ack));
    chk({tag, "_y"}, 32'(y), 32'(exp_y));
    chk({tag, "_lat"}, 32'(cyc), 32'(exp_lat));
    model_last = exp_id;
  endtask

  initial begin
    int bc;
    int g;
    logic [W-1:0] sa, sb, exp_y;
    logic [2:0] sop;
    logic [N-1:0] mask;
    logic [W-1:0] op_a [6];
    logic [2:0]   op_code [6];
    logic [W-1:0] op_exp [6];

    rst_n = 1'b0;
    req = '0;
    for (int i = 0; i < N; i++) begin
      ta[i] = '0; tb[i] = '0; top[i] = '0;
    end
    drive();
    repeat (2) step();
    rst_n = 1'b1;
    #1;
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_y", 32'(y), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // Single XOR on requester 0
    ta[0] = 16'hFF00; tb[0] = 16'h0F0F; top[0] = 3'd3;
    req = 4'b0001;
    drive();
    step();
    chk("xor_busy_capture", 32'(busy), 32'h1);
    req = '0;
    wait_ack("xor", 0, 16'hF00F, 17, bc);
    chk("xor_busy_cycles", 32'(bc + 1), 32'd17);
    chk("xor_busy_after", 32'(busy), 32'h0);

    // All opcodes on requester 2
    op_a[0] = 16'hFFFF; op_code[0] = 3'd0; op_exp[0] = 16'hEDCB;
    op_a[1] = 16'hFFFF; op_code[1] = 3'd1; op_exp[1] = 16'h1234;
    op_a[2] = 16'hFFFF; op_code[2] = 3'd2; op_exp[2] = 16'hFFFF;
    op_a[3] = 16'h00FF; op_code[3] = 3'd4; op_exp[3] = 16'hFF00;
    op_a[4] = 16'hFFFF; op_code[4] = 3'd6; op_exp[4] = 16'h0000;
    op_a[5] = 16'hFFFF; op_code[5] = 3'd3; op_exp[5] = 16'hEDCB;
    req = 4'b0100;
    for (int k = 0; k < 6; k++) begin
      ta[2] = op_a[k]; tb[2] = 16'h1234; top[2] = op_code[k];
      drive();
      wait_ack($sformatf("opc%0d", k), 2, op_exp[k], 18, bc);
    end
    req = '0;

    // Fairness from a fresh reset with every requester asserted
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    model_last = N - 1;
    for (int i = 0; i < N; i++) randomize_req(i);
    req = 4'b1111;
    drive();
    for (int k = 0; k < 8; k++) begin
      g = k % N;
      exp_y = ref_op(ta[g], tb[g], top[g]);
      wait_ack($sformatf("fair%0d", k), g, exp_y, 18, bc);
      randomize_req(g);
      drive();
    end
    req = '0;

    // Operand change after capture must not affect requester 1
    sa = W'($urandom); sb = W'($urandom); sop = 3'($urandom_range(0, 4));
    ta[1] = sa; tb[1] = sb; top[1] = sop;
    req = 4'b0010;
    drive();
    step();
    ta[1] = ~sa; tb[1] = ~sb; top[1] = sop + 3'd1;
    drive();
    wait_ack("opchg", 1, ref_op(sa, sb, sop), 17, bc);
    req = '0;

    // Reset in the middle of a shift
    randomize_req(0);
    ta[0] = 16'hA5A5; top[0] = 3'd4;
    req = 4'b0001;
    drive();
    wait_ack("pre_rst", 0, ref_op(ta[0], tb[0], top[0]), 18, bc);
    ta[0] = 16'h1111; top[0] = 3'd2;
    drive();
    step();
    repeat (8) step();
    req = '0;
    rst_n = 1'b0;
    #1;
    chk("midrst_ack", 32'(ack), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_y", 32'(y), 32'h0);
    step();
    step();
    chk("midrst_hold_ack", 32'(ack), 32'h0);
    rst_n = 1'b1;
    model_last = N - 1;
    randomize_req(1);
    randomize_req(3);
    req = 4'b1010;
    drive();
    wait_ack("postrst_r1", 1, ref_op(ta[1], tb[1], top[1]), 18, bc);
    req = 4'b1000;
    wait_ack("postrst_r3", 3, ref_op(ta[3], tb[3], top[3]), 18, bc);

    // Requester 3 withdraws during the shift
    randomize_req(3);
    req = 4'b1000;
    drive();
    step();
    repeat (3) step();
    req = '0;
    wait_ack("withdraw", 3, ref_op(ta[3], tb[3], top[3]), 14, bc);
    step();
    chk("withdraw_idle_busy", 32'(busy), 32'h0);
    chk("withdraw_idle_ack", 32'(ack), 32'h0);

    // Random masks and operands checked against the model
    for (int k = 0; k < 12; k++) begin
      mask = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) randomize_req(i);
      req = mask;
      drive();
      g = next_grant(mask, model_last);
      wait_ack($sformatf("rnd%0d", k), g, ref_op(ta[g], tb[g], top[g]), 18, bc);
    end
    req = '0;
    step();
    step();
    chk("final_busy", 32'(busy), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
